// File: rtl/mips_io_pkg.sv
// Shared register-map constants for the memory-mapped I/O peripherals on the
// 8-bit mips_mem bus.
package mips_io_pkg;

    localparam logic [1:0] OFF_SCRATCH = 2'd0;
    localparam logic [1:0] OFF_COUNT   = 2'd1;
    localparam logic [1:0] OFF_STATUS  = 2'd2;
    localparam logic [1:0] OFF_DATA    = 2'd3;

    localparam int ST_EMPTY = 0;
    localparam int ST_FULL  = 1;
    localparam int ST_OVF   = 2;

    localparam logic [7:0] IO_BASE = 8'hFC;

endpackage

// File: rtl/io_fifo.sv
// Synchronous FIFO with occupancy counter; a push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module io_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // Head is forced to zero when empty so stale storage never leaks out.
    assign dout = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers are AW bits wide, so wrapping modulo DEPTH is implicit.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mmio_out_port.sv
// Memory-mapped output port: a 4-byte register window whose DATA register
// feeds a FIFO drained over a valid/ready handshake.
module mmio_out_port
    import mips_io_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] BASE  = IO_BASE,
    parameter int               DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] adr,
    input  logic [WIDTH-1:0] writedata,
    input  logic             memwrite,
    input  logic             memread,
    output logic [WIDTH-1:0] readdata,
    output logic             io_sel,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic             hit;
    logic [1:0]       off;
    logic             wr_hit;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic [CW-1:0]    count;
    logic             ovf;
    logic [WIDTH-1:0] scratch;
    logic [WIDTH-1:0] data_shadow;
    logic [WIDTH-1:0] status;
    logic [WIDTH-1:0] rd_mux;

    assign hit       = (adr[WIDTH-1:2] == BASE[WIDTH-1:2]);
    assign off       = adr[1:0];
    assign wr_hit    = memwrite & hit;
    assign push      = wr_hit & (off == OFF_DATA);
    assign out_valid = ~empty;
    assign pop       = out_valid & out_ready;

    io_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (writedata),
        .dout  (out_data),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_comb begin
        status           = '0;
        status[ST_EMPTY] = empty;
        status[ST_FULL]  = full;
        status[ST_OVF]   = ovf;
    end

    always_comb begin
        rd_mux = '0;
        case (off)
            OFF_SCRATCH: rd_mux = scratch;
            OFF_COUNT:   rd_mux = WIDTH'(count);
            OFF_STATUS:  rd_mux = status;
            OFF_DATA:    rd_mux = data_shadow;
            default:     rd_mux = '0;
        endcase
    end

    // A push that finds the FIFO full with no concurrent pop is dropped and
    // latches ovf until software clears it through STATUS bit 2.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf         <= 1'b0;
            scratch     <= '0;
            data_shadow <= '0;
        end else begin
            if (push && full && !pop) begin
                ovf <= 1'b1;
            end else if (wr_hit && (off == OFF_STATUS) && writedata[ST_OVF]) begin
                ovf <= 1'b0;
            end
            if (wr_hit && (off == OFF_SCRATCH)) begin
                scratch <= writedata;
            end
            if (push) begin
                data_shadow <= writedata;
            end
        end
    end

    // Read path samples pre-edge state, so a simultaneous store is not visible.
    always_ff @(posedge clk) begin
        if (reset) begin
            readdata <= '0;
            io_sel   <= 1'b0;
        end else if (memread && hit) begin
            readdata <= rd_mux;
            io_sel   <= 1'b1;
        end else begin
            io_sel   <= 1'b0;
        end
    end

endmodule

// File: doc/mmio_out_port.md
Name: mmio_out_port

Overview:
- Memory-mapped output peripheral on the 8-bit mips_mem data bus.
- It is the responder to the CPU's load/store initiator and decodes a 4-byte window at the top of the address space.
- Stores to the DATA register are queued in a FIFO and drained to an external consumer over a valid/ready handshake.
- The CPU reads back status, occupancy and a scratch register through a registered read path.

Parameters:
- WIDTH, 8, data and address width in bits (matches the CPU WIDTH).
- BASE, 8'hFC, window base; must be 4-byte aligned; decode is adr[WIDTH-1:2]==BASE[WIDTH-1:2].
- DEPTH, 4, output FIFO depth; power of two, at least 2.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- adr  in  WIDTH  CPU byte address.
- writedata  in  WIDTH  CPU store data.
- memwrite  in  1  CPU store strobe, one cycle per store.
- memread  in  1  CPU load strobe.
- readdata  out  WIDTH  registered load data.
- io_sel  out  1  high the cycle readdata is valid for a window hit; mips_mem muxes on it.
- out_data  out  WIDTH  FIFO head.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts the head when high with out_valid.

Behaviour:
- Register map, offset from BASE:
  - +0 SCRATCH: read/write.
  - +1 COUNT: read-only, FIFO occupancy 0..DEPTH, zero-extended.
  - +2 STATUS: reads {zeros, ovf, full, empty} in bits [2:0]. Writing with writedata[2]=1 clears ovf; other bits are ignored.
  - +3 DATA: a write pushes writedata. A read returns the last value written to DATA, not the FIFO head.
- Hit rule: hit = (adr[WIDTH-1:2]==BASE[WIDTH-1:2]). Accesses outside the window are ignored entirely, and io_sel stays 0.
- Read latency is 1 cycle:
  - On an edge with memread & hit, readdata <= selected register, sampled from pre-edge state, and io_sel <= 1.
  - Otherwise io_sel <= 0 and readdata holds its value.
- Push/pop:
  - push = memwrite & hit & offset==3.
  - pop = out_valid & out_ready.
  - Push when not full: enqueue.
  - Push when full with no pop: drop the data, set ovf (sticky), leave DATA shadow updated.
  - Push when full with a pop in the same cycle: accept; occupancy is unchanged and ovf is not set.
  - Pop when empty: impossible, since out_valid=0.
  - Push when empty: out_valid rises the next cycle and out_data equals that value; there is no same-cycle bypass.
- Pointers wrap modulo DEPTH. Occupancy is held in a counter of clog2(DEPTH)+1 bits.
- memread and memwrite both asserted in the same cycle: both are performed; the read sees pre-write state.
- Reset, including mid-drain or mid-read:
  - FIFO is emptied and ovf cleared.
  - SCRATCH=0, DATA shadow=0, readdata=0, io_sel=0, out_valid=0, out_data=0.
  - In-flight data is discarded.
- out_data is 0 whenever the FIFO is empty.

Decomposition:
- Shared package mips_io_pkg holds:
  - Offset constants OFF_SCRATCH=0, OFF_COUNT=1, OFF_STATUS=2, OFF_DATA=3.
  - Status bit positions ST_EMPTY=0, ST_FULL=1, ST_OVF=2.
  - Default base IO_BASE=8'hFC.
- One sub-module, io_fifo:
  - Parameterised WIDTH/DEPTH synchronous FIFO.
  - Push/pop/full/empty/count interface with the simultaneous full push+pop rule above.
- mmio_out_port contains the decode logic, register file, ovf flag and read mux.

Test Plan:
- Store 8'h0D to 8'hFF, out_ready=0 -> next cycle out_valid=1, out_data=8'h0D. Load 8'hFD -> one cycle later io_sel=1, readdata=8'h01. Load 8'hFF -> readdata=8'h0D.
- out_ready=0; store 1,2,3,4,5 to 8'hFF -> COUNT=4; STATUS=8'b110 (ovf and full set). Raise out_ready -> drains 1,2,3,4 on consecutive cycles, then out_valid=0 and STATUS=8'b101.
- FIFO full and out_ready=1; store 8'hAA in the same cycle as a pop -> COUNT stays 4, ovf=0, and 8'hAA appears last in the drain.
- Store 8'h04 to 8'hFE with ovf set -> STATUS reads 8'b001 once empty. Store 8'h5A to 8'hFC, load 8'hFC -> readdata=8'h5A.
- Store to 8'hFB, load 8'h10 -> no FIFO change, io_sel stays 0, readdata unchanged.
- Three entries queued, a load in flight; assert reset one cycle -> next cycle out_valid=0, io_sel=0, readdata=0, COUNT reads 0 after release.
